// File: rtl/mdu_iter_if.sv
// Issue/result bundle for the iterative multiply/divide unit.
// The slave side is the MDU; the master side is the decoder (or a bench).
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave  (input  start, op, a, b, flush,
                  output busy, done, div_zero, hi, lo);
  modport master (output start, op, a, b, flush,
                  input  busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide. Signed ops
// run on magnitudes, and a final FIX cycle restores the signs.
// Optional: define MDU_EARLY_OUT_EN to skip CALC for trivial operands
// (zero multiply operand, or dividend magnitude below divisor magnitude).
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  mdu_iter_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q;
  logic [CW-1:0]      iter_q;
  logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw_q;    // original dividend, returned as HI on divide by zero
  logic               is_div_q;
  logic               neg_q;      // product / quotient needs negation
  logic               rneg_q;     // remainder needs negation
  logic               dz_q;       // divide by zero detected at accept
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               sgn_d;
  logic [WIDTH-1:0]   a_mag_d, b_mag_d;
  logic               fast_d;
  logic [WIDTH:0]     sum_d, rem_sh_d, diff_d;
  logic [2*WIDTH-1:0] mul_nxt_d, div_nxt_d, prod_d;
  logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // Operand magnitudes at issue, one iteration step, and the sign-fixed result.
  always_comb begin
    sgn_d   = ~bus.op[0];
    a_mag_d = (sgn_d && bus.a[WIDTH-1]) ? (WIDTH'(0) - bus.a) : bus.a;
    b_mag_d = (sgn_d && bus.b[WIDTH-1]) ? (WIDTH'(0) - bus.b) : bus.b;
`ifdef MDU_EARLY_OUT_EN
    fast_d  = bus.op[1] ? ((b_mag_d != '0) && (a_mag_d < b_mag_d))
                        : ((bus.a == '0) || (bus.b == '0));
`else
    fast_d  = 1'b0;
`endif

    // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right.
    sum_d     = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    mul_nxt_d = {sum_d, acc_q[WIDTH-1:1]};

    // Restoring divide: shift in the next dividend bit, keep the difference if no borrow.
    rem_sh_d  = acc_q[2*WIDTH-1:WIDTH-1];
    diff_d    = rem_sh_d - {1'b0, opnd_q};
    div_nxt_d = diff_d[WIDTH] ? {rem_sh_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {diff_d[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    prod_d = neg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    if (!is_div_q) begin
      fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_d[WIDTH-1:0];
    end else if (dz_q) begin
      fix_hi_d = a_raw_q;
      fix_lo_d = '1;
    end else begin
      fix_hi_d = rneg_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
      fix_lo_d = neg_q  ? (WIDTH'(0) - acc_q[WIDTH-1:0])       : acc_q[WIDTH-1:0];
    end
  end

  // Control FSM with registered outputs; flush only acts while busy, and wins over start.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      iter_q     <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            case (bus.op)
              3'd4: hi_q <= bus.a;
              3'd5: lo_q <= bus.a;
              3'd0, 3'd1, 3'd2, 3'd3: begin
                busy_q     <= 1'b1;
                div_zero_q <= 1'b0;
                iter_q     <= '0;
                is_div_q   <= bus.op[1];
                neg_q      <= sgn_d & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                rneg_q     <= sgn_d & bus.a[WIDTH-1];
                dz_q       <= bus.op[1] && (bus.b == '0);
                a_raw_q    <= bus.a;
                opnd_q     <= bus.op[1] ? b_mag_d : a_mag_d;
                if (fast_d) begin
                  // Trivial result: product 0, or quotient 0 with remainder |a|.
                  acc_q   <= bus.op[1] ? {a_mag_d, {WIDTH{1'b0}}} : '0;
                  state_q <= S_FIX;
                end else begin
                  acc_q   <= bus.op[1] ? {{WIDTH{1'b0}}, a_mag_d} : {{WIDTH{1'b0}}, b_mag_d};
                  state_q <= S_CALC;
                end
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q  <= is_div_q ? div_nxt_d : mul_nxt_d;
            iter_q <= iter_q + 1'b1;
            if (iter_q == LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!bus.flush) begin
            hi_q       <= fix_hi_d;
            lo_q       <= fix_lo_d;
            div_zero_q <= dz_q;
            done_q     <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): directed plan cases plus
// random ops, checked against a plain-arithmetic reference model.
module tb_mdu_iter;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] m_hi, m_lo;
  bit          m_dz;

  mdu_iter_if #(.WIDTH(32)) bus();
  mdu_iter #(.WIDTH(32)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results from integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] eh, output logic [31:0] el, output bit edz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    edz = 1'b0;
    case (o)
      3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'd1: begin p = {32'b0, av} * {32'b0, bv}; eh = p[63:32]; el = p[31:0]; end
      3'd2: begin
        if (bv == 0) begin el = '1; eh = av; edz = 1'b1; end
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin el = av; eh = '0; end
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      default: begin
        if (bv == 0) begin el = '1; eh = av; edz = 1'b1; end
        else begin el = av / bv; eh = av % bv; end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] am, bm;
    am = (o[0] == 1'b0 && av[31]) ? -av : av;
    bm = (o[0] == 1'b0 && bv[31]) ? -bv : bv;
    if (o[1] == 1'b0 && (av == 0 || bv == 0)) return 1;
    if (o[1] == 1'b1 && bm != 0 && am < bm) return 1;
`endif
    return (o == 3'd7) ? 0 : 33;
  endfunction

  // Issue op 0-3; kind: 0 none, 1 stray MULTU start, 2 flush, 3 reset at edge k+poke_at.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_at, input int kind, input string tag);
    logic [31:0] eh, el;
    bit edz;
    int lat, cyc, ndone;
    model(o, av, bv, eh, el, edz);
    lat = exp_lat(o, av, bv);
    @(negedge CLK);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    m_dz = 1'b0;
    chk({tag, " busy_after_accept"}, bus.busy, 1);
    chk({tag, " hi_hold"}, bus.hi, m_hi);
    cyc = 0; ndone = 0;
    while (cyc < 40) begin
      if (kind != 0 && cyc + 1 == poke_at) begin
        if (kind == 1) begin bus.start = 1'b1; bus.op = 3'd1; bus.a = $urandom; bus.b = $urandom; end
        if (kind == 2) bus.flush = 1'b1;
        if (kind == 3) RST_N = 1'b0;
      end
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      bus.start = 1'b0; bus.flush = 1'b0; RST_N = 1'b1;
      if (kind >= 2 && cyc == poke_at) begin
        if (kind == 3) begin m_hi = '0; m_lo = '0; m_dz = 1'b0; end
        chk({tag, " busy_after_abort"}, bus.busy, 0);
        chk({tag, " hi_after_abort"}, bus.hi, m_hi);
        chk({tag, " lo_after_abort"}, bus.lo, m_lo);
        chk({tag, " dz_after_abort"}, bus.div_zero, m_dz);
      end
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          chk({tag, " latency"}, cyc, lat);
          chk({tag, " hi"}, bus.hi, eh);
          chk({tag, " lo"}, bus.lo, el);
          chk({tag, " div_zero"}, bus.div_zero, edz);
          chk({tag, " busy_at_done"}, bus.busy, 0);
          m_hi = eh; m_lo = el; m_dz = edz;
        end
      end
      if (kind < 2 && ndone > 0 && cyc >= lat + 1) break;
    end
    chk({tag, " done_pulses"}, ndone, (kind >= 2) ? 0 : 1);
  endtask

  // Single-cycle IDLE issue (MTHI/MTLO/reserved), optionally with flush.
  task automatic mt(input logic [2:0] o, input logic [31:0] av, input bit fl, input string tag);
    @(negedge CLK);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.flush = fl;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0; bus.flush = 1'b0;
    if (!fl && o == 3'd4) m_hi = av;
    if (!fl && o == 3'd5) m_lo = av;
    chk({tag, " hi"}, bus.hi, m_hi);
    chk({tag, " lo"}, bus.lo, m_lo);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset div_zero", bus.div_zero, 0);
    chk("reset hi", bus.hi, 0);
    chk("reset lo", bus.lo, 0);
    RST_N = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, "mult_neg");
    chk("mult_neg hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg lo_const", bus.lo, 32'hFFFF_FFF1);
    run_op(3'd3, 32'd7, 32'd2, 0, 0, "divu_7_2");
    chk("divu_7_2 lo_const", bus.lo, 32'd3);
    chk("divu_7_2 hi_const", bus.hi, 32'd1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7_2");
    chk("div_m7_2 lo_const", bus.lo, 32'hFFFF_FFFD);
    chk("div_m7_2 hi_const", bus.hi, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h0000_000C, 32'd0, 0, 0, "div_by_zero");
    chk("div_by_zero lo_const", bus.lo, 32'hFFFF_FFFF);
    chk("div_by_zero dz_const", bus.div_zero, 1);
    mt(3'd5, 32'h0000_0055, 1'b0, "mtlo");
    chk("mtlo lo_const", bus.lo, 32'h55);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1, "div_ovf_stray_start");
    chk("div_ovf lo_const", bus.lo, 32'h8000_0000);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 2, "multu_flush");
    run_op(3'd1, 32'h0001_2345, 32'h0000_6789, 20, 3, "multu_reset");
    run_op(3'd0, 32'd0, 32'd1234, 0, 0, "mult_zero");
    run_op(3'd3, 32'd5, 32'd9, 0, 0, "divu_small");
    run_op(3'd2, 32'hFFFF_FFFB, 32'd9, 0, 0, "div_small_neg");
    mt(3'd6, 32'hDEAD_BEEF, 1'b0, "reserved_op");
    mt(3'd4, 32'hCAFE_0001, 1'b1, "flush_beats_mthi");
    mt(3'd4, 32'h1234_5678, 1'b0, "mthi");

    for (int i = 0; i < 12; i++) begin
      logic [2:0]  o;
      logic [31:0] av, bv;
      o  = 3'($urandom_range(0, 3));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 3))
        0: bv = 32'($urandom_range(0, 15));
        1: bv = {{16{bv[31]}}, bv[15:0]};
        default: ;
      endcase
      run_op(o, av, bv, 0, 0, $sformatf("rand%0d_op%0d", i, o));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit with HI/LO result registers for the 32-bit MIPS-style core.
- Parametrised in datapath width.
- Sits beside the single-cycle ALU and is issued by the decoder. The pipeline stalls on `busy`.
- One result bit per cycle: shift-add for multiply, restoring division for divide. Signed operations are handled by magnitude conversion plus a final sign-fix cycle.

Parameters:
WIDTH, 32, operand/HI/LO width; legal range 8..64.

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  synchronous active-low reset
start  in  1  issue request, sampled on CLK
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 reserved
a  in  WIDTH  operand A (multiplicand/dividend/MTHI-MTLO data)
b  in  WIDTH  operand B (multiplier/divisor)
flush  in  1  abort in-flight operation
busy  out  1  operation in flight, start ignored
done  out  1  one-cycle pulse: HI/LO updated by MULT/DIV
div_zero  out  1  sticky-per-op flag: last DIV/DIVU had b==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (RST_N=0 at edge) clears all state: `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, FSM=IDLE.
  - Reset overrides `start`, `flush` and any in-flight operation.
- FSM states: IDLE, CALC, FIX.
- **IDLE**: `start`=1 at edge k is accepted.
  - op 4/5: `hi` (or `lo`) <= `a` at edge k. No `busy`, no `done`, FSM stays IDLE.
  - op 6/7: ignored, no state change.
  - op 0-3: latch magnitudes; record result signs (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa).
    - `busy`<=1, `div_zero`<=0, `iter_cnt`<=0, go CALC.
- **CALC**: one iteration per edge, edges k+1..k+WIDTH. `iter_cnt` counts 0..WIDTH-1; at WIDTH-1 go FIX.
  - Multiply: 2*WIDTH-bit accumulator; add multiplicand if multiplier LSB=1, then shift right.
  - Divide: shift remainder left, trial-subtract divisor, set quotient bit if no borrow.
- **FIX** (edge k+WIDTH+1): apply two's-complement sign fix for signed ops and write `hi`/`lo`. Same edge: `done`<=1, `busy`<=0, go IDLE.
  - `done` is high exactly one cycle. First new `start` is accepted at edge k+WIDTH+2.
- Result mapping:
  - Multiply: {hi, lo} = full 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder (remainder sign follows dividend).
- Divide by zero: detected at accept. Still runs full latency. Result lo = all ones, hi = `a` unchanged; `div_zero`=1 with `done`.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0, `div_zero`=0.
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO.
- `flush`=1 while `busy`: go IDLE, `busy`<=0, no `done`; `hi`/`lo`/`div_zero` unchanged.
- `flush` and `start` in the same IDLE cycle: `flush` wins, `start` dropped.
- `hi`/`lo` hold their values during CALC; visible only after FIX.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: at accept, the fast path applies when either:
  - multiply with `a`==0 or `b`==0, or
  - unsigned-magnitude divide with |a| < |b| and `b`!=0.
- Fast path skips CALC and goes straight to FIX. The result is written and `done` pulses at edge k+1. `busy` is high for one cycle.
- Results are bit-identical to the full path.
- Undefined: every op 0-3 takes exactly WIDTH+1 cycles.

Test Plan:
- WIDTH=32. MULT a=FFFFFFFD (-3), b=5, start at edge k -> `busy` 1 from k, `done` pulse at k+33, hi=FFFFFFFF, lo=FFFFFFF1.
- DIVU a=7 b=2 -> lo=3, hi=1. DIV a=FFFFFFF9 (-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF, `div_zero`=0.
- DIV a=0000000C b=0 -> `done` at k+33, lo=FFFFFFFF, hi=0000000C, `div_zero`=1. Then MTLO a=00000055 in IDLE -> lo=00000055 next cycle, no `done`.
- DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0. Second `start` (MULTU) pulsed at k+10 -> ignored, results unchanged, only one `done`.
- MULTU a=FFFFFFFF b=FFFFFFFF, `flush` at k+5 -> `busy` 0 next cycle, no `done`, hi/lo keep prior values.
- MULTU in flight, RST_N=0 at k+20 -> all outputs 0 after that edge. With MDU_EARLY_OUT_EN: MULT a=0 b=1234 -> `done` at k+1, hi=lo=0.
